// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status readback

// Circular byte queue; pointers carry one extra wrap bit so full and empty are distinguishable.
module io_uart_tx_fifo #(
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          RESET,
   input  logic          push,
   input  logic [7:0]    wdata,
   input  logic          pop,
   output logic [7:0]    rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam int DEPTH = 1 << AW;

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   // A full queue refuses the push even when a pop happens in the same cycle.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Pointer update; both pointers wrap naturally through the extra MSB.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// Transmitter top: IO+12 write decode, overflow flag, status readback and 8N1 serialiser.
module io_uart_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_AW      = 2
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        io_sel,
   input  logic [1:0]  io_addr,
   input  logic [31:0] io_wdata,
   input  logic [4:0]  io_wmask,
   output logic [31:0] io_rdata,
   output logic        uart_tx,
   output logic        tx_busy
);

   localparam int             CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     clk_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift;
   logic              tx_nxt;
   logic              bit_end;
   logic              pop;

   logic              reg_hit;
   logic              wr;
   logic              push;
   logic              overflow;

   logic [7:0]        fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_AW:0]  fifo_count;
   logic [31:0]       cnt_ext;
   logic              unused_ok;

   assign reg_hit = io_sel & (io_addr == 2'b11);
   assign wr      = reg_hit & io_wmask[0];
   // Bit 8 set turns the store into an overflow-clear command instead of a data byte.
   assign push    = wr & ~io_wdata[8];
   assign bit_end = (clk_cnt == CNT_LAST);
   assign tx_busy = (state != IDLE) | ~fifo_empty;
   assign cnt_ext = 32'(fifo_count);

   assign unused_ok = &{1'b0, io_wdata[31:9], io_wmask[4:1], cnt_ext[31:3]};

   io_uart_tx_fifo #(
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .RESET (RESET),
      .push  (push),
      .wdata (io_wdata[7:0]),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Sticky overflow: set when a byte is dropped on a full queue, cleared by a bit-8 store.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         overflow <= 1'b0;
      end else if (wr && io_wdata[8]) begin
         overflow <= 1'b0;
      end else if (push && fifo_full) begin
         overflow <= 1'b1;
      end
   end

   // Status readback registered to line up with the RAM read latency.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         io_rdata <= 32'b0;
      end else if (reg_hit) begin
         io_rdata <= {25'b0, cnt_ext[2:0], 1'b0, overflow, fifo_full, tx_busy};
      end else begin
         io_rdata <= 32'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and pop decision; STOP chains straight into START when more bytes wait.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            if (bit_end && (bit_cnt == 3'd7)) state_nxt = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bit timing and shift register; a pop reloads the shifter and restarts the bit timer.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         clk_cnt <= '0;
         bit_cnt <= 3'd0;
         shift   <= 8'd0;
      end else if (pop) begin
         clk_cnt <= '0;
         shift   <= fifo_rdata;
      end else if (state != IDLE) begin
         clk_cnt <= bit_end ? '0 : clk_cnt + CW'(1);
         if (bit_end) begin
            if (state == START) begin
               bit_cnt <= 3'd0;
            end else if (state == DATA) begin
               shift   <= {1'b0, shift[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
   end

   // Line level implied by the current state; LSB first during DATA.
   always_comb begin
      tx_nxt = 1'b1;
      case (state)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shift[0];
         default: tx_nxt = 1'b1;
      endcase
   end

   // Registered serial output, one cycle behind the state so every bit is glitch-free.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         uart_tx <= 1'b1;
      end else begin
         uart_tx <= tx_nxt;
      end
   end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - directed self-checking bench for io_uart_tx

module tb_io_uart_tx;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        RESET;
   logic        io_sel;
   logic [1:0]  io_addr;
   logic [31:0] io_wdata;
   logic [4:0]  io_wmask;
   logic [31:0] io_rdata;
   logic        uart_tx;
   logic        tx_busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] rx_q[$];
   int         rx_t[$];
   int         rx_stop_bad = 0;
   bit         rx_abort    = 1'b0;

   io_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_AW      (2)
   ) dut (
      .clk      (clk),
      .RESET    (RESET),
      .io_sel   (io_sel),
      .io_addr  (io_addr),
      .io_wdata (io_wdata),
      .io_wmask (io_wmask),
      .io_rdata (io_rdata),
      .uart_tx  (uart_tx),
      .tx_busy  (tx_busy)
   );

   always #5 clk = ~clk;

   // cyc holds the number of the most recent rising edge
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Serial receiver model: records each byte and the edge number where its start bit began
   initial begin
      int         ph;
      int         s;
      logic [7:0] sh;
      ph = -1;
      s  = 0;
      sh = 8'd0;
      forever begin
         @(negedge clk);
         if (rx_abort) begin
            ph = -1;
         end else if (ph < 0) begin
            if (uart_tx === 1'b0) begin
               ph = 0;
               s  = cyc;
            end
         end else begin
            ph++;
            if (ph >= CPB + 1 && ph <= 8 * CPB + 1 && ((ph - 1) % CPB) == 0)
               sh = {uart_tx, sh[7:1]};
            if (ph == 9 * CPB + 1) begin
               if (uart_tx !== 1'b1) rx_stop_bad++;
               rx_q.push_back(sh);
               rx_t.push_back(s);
               ph = -1;
            end
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle_bus();
      io_sel   = 1'b0;
      io_addr  = 2'b00;
      io_wdata = 32'd0;
      io_wmask = 5'd0;
   endtask

   // Called at a falling edge; returns at the next falling edge with e = accepting edge number
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int e);
      io_sel   = 1'b1;
      io_addr  = a;
      io_wdata = d;
      io_wmask = 5'b00001;
      @(negedge clk);
      e = cyc;
   endtask

   task automatic bus_read(input logic sel, input logic [1:0] a, output logic [31:0] d);
      io_sel   = sel;
      io_addr  = a;
      io_wdata = 32'd0;
      io_wmask = 5'd0;
      @(negedge clk);
      d = io_rdata;
      idle_bus();
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k;
      k = 0;
      while (rx_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check_val("frame_timeout", 32'(rx_q.size() >= n), 32'd1);
   endtask

   initial begin
      logic [31:0] d;
      logic [7:0]  burst[5];
      int          e;
      int          e0;
      int          et;
      int          base;
      bit          saw_low;

      idle_bus();
      RESET = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_uart_tx", 32'(uart_tx), 32'd1);
      check_val("rst_busy", 32'(tx_busy), 32'd0);
      check_val("rst_rdata", io_rdata, 32'd0);
      RESET = 1'b0;

      // 1: quiet line with no writes
      saw_low = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) saw_low = 1'b1;
      end
      check_val("idle_line_low", 32'(saw_low), 32'd0);
      check_val("idle_busy", 32'(tx_busy), 32'd0);
      bus_read(1'b1, 2'b11, d);
      check_val("idle_status", d, 32'd0);

      // 2: single byte 0x55, latency and busy window
      bus_write(2'b11, 32'h55, e);
      idle_bus();
      check_val("t2_busy_rise", 32'(tx_busy), 32'd1);
      wait_frames(1, 100);
      check_val("t2_byte", 32'(rx_q[0]), 32'h55);
      check_val("t2_start_lat", 32'(rx_t[0] - e), 32'd2);
      while (cyc < e + 40) @(negedge clk);
      check_val("t2_busy_last", 32'(tx_busy), 32'd1);
      @(negedge clk);
      check_val("t2_busy_fall", 32'(tx_busy), 32'd0);
      check_val("t2_line_stop", 32'(uart_tx), 32'd1);

      // 3: leader byte keeps the FSM busy, then A1..A5 back to back; A5 overflows
      base = rx_q.size();
      burst = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      bus_write(2'b11, 32'h0F, e0);
      for (int i = 0; i < 5; i++) bus_write(2'b11, {24'd0, burst[i]}, et);
      idle_bus();
      bus_read(1'b1, 2'b11, d);
      check_val("t3_status_ovf", d, 32'h47);

      // 4: overflow clear command, queue untouched
      bus_write(2'b11, 32'h100, et);
      idle_bus();
      bus_read(1'b1, 2'b11, d);
      check_val("t4_status_clr", d, 32'h43);
      wait_frames(base + 5, 5 * 10 * CPB + 100);
      check_val("t3_lead_byte", 32'(rx_q[base]), 32'h0F);
      check_val("t3_lead_lat", 32'(rx_t[base] - e0), 32'd2);
      for (int i = 1; i < 5; i++) begin
         check_val($sformatf("t3_byte%0d", i), 32'(rx_q[base + i]), 32'(burst[i - 1]));
         check_val($sformatf("t3_gap%0d", i), 32'(rx_t[base + i] - rx_t[base + i - 1]), 32'(10 * CPB));
      end
      repeat (60) @(negedge clk);
      check_val("t4_no_extra", 32'(rx_q.size()), 32'(base + 5));
      check_val("t4_busy_done", 32'(tx_busy), 32'd0);

      // 5: status with 2 queued and a frame active; decode misses
      base = rx_q.size();
      bus_write(2'b11, 32'hB1, e);
      bus_write(2'b11, 32'hB2, et);
      bus_write(2'b11, 32'hB3, et);
      idle_bus();
      bus_read(1'b1, 2'b11, d);
      check_val("t5_status", d, 32'h21);
      bus_read(1'b1, 2'b01, d);
      check_val("t5_addr01", d, 32'd0);
      bus_read(1'b0, 2'b11, d);
      check_val("t5_nosel", d, 32'd0);
      bus_write(2'b01, 32'h77, et);
      idle_bus();
      bus_read(1'b1, 2'b11, d);
      check_val("t5_status_after_miss", d, 32'h21);
      wait_frames(base + 3, 3 * 10 * CPB + 100);
      check_val("t5_lat", 32'(rx_t[base] - e), 32'd2);
      check_val("t5_b1", 32'(rx_q[base]), 32'hB1);
      check_val("t5_b2", 32'(rx_q[base + 1]), 32'hB2);
      check_val("t5_b3", 32'(rx_q[base + 2]), 32'hB3);
      repeat (60) @(negedge clk);
      check_val("t5_no_extra", 32'(rx_q.size()), 32'(base + 3));

      // 6: async reset during data bit 3 of 0xC3 with 0xD4 queued
      base = rx_q.size();
      bus_write(2'b11, 32'hC3, e);
      bus_write(2'b11, 32'hD4, et);
      idle_bus();
      while (cyc < e + 20) @(negedge clk);
      check_val("t6_mid_bit3", 32'(uart_tx), 32'd0);
      #2;
      RESET    = 1'b1;
      rx_abort = 1'b1;
      #1;
      check_val("t6_async_line", 32'(uart_tx), 32'd1);
      check_val("t6_async_busy", 32'(tx_busy), 32'd0);
      @(negedge clk);
      @(negedge clk);
      RESET    = 1'b0;
      rx_abort = 1'b0;
      bus_read(1'b1, 2'b11, d);
      check_val("t6_status", d, 32'd0);
      check_val("t6_no_partial", 32'(rx_q.size()), 32'(base));
      repeat (5) @(negedge clk);
      bus_write(2'b11, 32'h5A, e);
      idle_bus();
      wait_frames(base + 1, 100);
      check_val("t6_clean_byte", 32'(rx_q[base]), 32'h5A);
      check_val("t6_clean_lat", 32'(rx_t[base] - e), 32'd2);
      repeat (60) @(negedge clk);
      check_val("t6_queue_lost", 32'(rx_q.size()), 32'(base + 1));
      check_val("stop_bits", 32'(rx_stop_bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
